// File: rtl/adc_pkg.sv
// Shared types and elaboration-time helpers for the multi-channel SPI ADC sampler.
package adc_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      SHIFT = 2'd2,
      LATCH = 2'd3
   } state_t;

   // clk cycles from cs_n falling to cs_n rising for one conversion frame
   function automatic int frame_cycles(input int frame_bits, input int sck_div);
      return (32'sd2 * frame_bits + 32'sd1) * sck_div + 32'sd1;
   endfunction

   // one extra SCK half-period plus a cycle of cs_n-high gap between frames
   function automatic int min_sample_div(input int frame_bits, input int sck_div);
      return frame_cycles(frame_bits, sck_div) + sck_div + 32'sd1;
   endfunction

   function automatic bit sample_div_ok(input int sample_div, input int frame_bits,
                                        input int sck_div);
      return sample_div >= min_sample_div(frame_bits, sck_div);
   endfunction

endpackage

// File: rtl/adc_spi_sampler_if.sv
// ADC pin bundle plus the valid/ack result stream of the sampler.
interface adc_spi_sampler_if #(
   parameter int N_CH   = 2,
   parameter int DATA_W = 12
);
   logic [N_CH-1:0]        miso;
   logic                   cs_n;
   logic                   sck;
   logic                   busy;
   logic [N_CH*DATA_W-1:0] data_out;
   logic                   valid;
   logic                   ack;
   logic                   overrun;

   modport master (
      input  miso, ack,
      output cs_n, sck, busy, data_out, valid, overrun
   );

   modport slave (
      output miso, ack,
      input  cs_n, sck, busy, data_out, valid, overrun
   );
endinterface

// File: rtl/adc_sck_gen.sv
// SCK divider: a leading high half-period (CS setup) followed by FRAME_BITS low/high periods.
module adc_sck_gen #(
   parameter int FRAME_BITS = 16,
   parameter int SCK_DIV    = 4,
   localparam int BIT_W     = $clog2(FRAME_BITS + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   output logic             sck,
   output logic             rise,
   output logic             fall,
   output logic [BIT_W-1:0] bit_cnt,
   output logic             frame_done
);

   localparam int DIV_W = $clog2(SCK_DIV + 1);

   logic [DIV_W-1:0] div_cnt;
   logic             div_term;
   logic             bit_last;

   assign div_term   = (div_cnt == DIV_W'(SCK_DIV - 1));
   assign bit_last   = (bit_cnt == BIT_W'(FRAME_BITS));
   assign rise       = run & div_term & ~sck;
   assign fall       = run & div_term & sck & ~bit_last;
   assign frame_done = run & div_term & sck & bit_last;

   // half-period divider, SCK level and count of completed rising edges
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_cnt <= '0;
         sck     <= 1'b1;
         bit_cnt <= '0;
      end else if (!run) begin
         div_cnt <= '0;
         sck     <= 1'b1;
         bit_cnt <= '0;
      end else begin
         if (div_term) begin
            div_cnt <= '0;
         end else begin
            div_cnt <= div_cnt + 1'b1;
         end
         if (rise) begin
            sck     <= 1'b1;
            bit_cnt <= bit_cnt + 1'b1;
         end else if (fall) begin
            sck <= 1'b0;
         end else begin
            sck <= sck;
         end
      end
   end

endmodule

// File: rtl/adc_spi_sampler.sv
// Multi-channel SPI ADC front end with valid/ack result handshake and sticky overrun.
// Optional ADC_SAMPLER_AVG_EN: average 2^AVG_LOG2 frames per output sample.
module adc_spi_sampler
   import adc_pkg::*;
#(
   parameter int N_CH       = 2,
   parameter int DATA_W     = 12,
   parameter int FRAME_BITS = 16,
   parameter int SCK_DIV    = 4,
   parameter int SAMPLE_DIV = 2268,
   parameter int AVG_LOG2   = 2
) (
   input logic               clk,
   input logic               rst,
   input logic               enable,
   adc_spi_sampler_if.master bus
);

   localparam int TIMER_W = $clog2(SAMPLE_DIV);
   localparam int BIT_W   = $clog2(FRAME_BITS + 1);

   if (!sample_div_ok(SAMPLE_DIV, FRAME_BITS, SCK_DIV)) begin : g_chk_div
      $error("SAMPLE_DIV too small for one frame plus gap");
   end
   if (DATA_W > FRAME_BITS) begin : g_chk_width
      $error("DATA_W must not exceed FRAME_BITS");
   end
   if (SCK_DIV < 1 || AVG_LOG2 < 0) begin : g_chk_misc
      $error("SCK_DIV must be >= 1 and AVG_LOG2 >= 0");
   end

   state_t                       state;
   state_t                       state_next;
   logic [TIMER_W-1:0]           timer;
   logic                         start;
   logic                         run;
   logic                         sck_rise;
   logic                         sck_fall;
   logic                         frame_done;
   logic [BIT_W-1:0]             bit_cnt;
   logic [N_CH-1:0][DATA_W-1:0]  shreg;
   logic [N_CH*DATA_W-1:0]       latch_data;
   logic                         avg_full;
   logic                         latch_out;

   assign start     = enable && (timer == '0) && (state == IDLE);
   assign run       = (state == SETUP) || (state == SHIFT);
   assign latch_out = (state == LATCH) && avg_full;

   adc_sck_gen #(
      .FRAME_BITS (FRAME_BITS),
      .SCK_DIV    (SCK_DIV)
   ) u_sck_gen (
      .clk        (clk),
      .rst        (rst),
      .run        (run),
      .sck        (bus.sck),
      .rise       (sck_rise),
      .fall       (sck_fall),
      .bit_cnt    (bit_cnt),
      .frame_done (frame_done)
   );

   // conversion-start timer, parked at zero while sampling is disabled
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         timer <= '0;
      end else if (!enable) begin
         timer <= '0;
      end else if (timer == TIMER_W'(SAMPLE_DIV - 1)) begin
         timer <= '0;
      end else begin
         timer <= timer + 1'b1;
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // FSM next state; SETUP ends on the first SCK fall of the frame
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = SETUP; else state_next = IDLE;
         SETUP:   if (sck_fall && bit_cnt == '0) state_next = SHIFT; else state_next = SETUP;
         SHIFT:   if (frame_done) state_next = LATCH; else state_next = SHIFT;
         LATCH:   state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // chip select and busy flag
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.cs_n <= 1'b1;
         bus.busy <= 1'b0;
      end else if (start) begin
         bus.cs_n <= 1'b0;
         bus.busy <= 1'b1;
      end else if (state == LATCH) begin
         bus.cs_n <= 1'b1;
         bus.busy <= 1'b0;
      end else begin
         bus.cs_n <= bus.cs_n;
         bus.busy <= bus.busy;
      end
   end

   // per-channel shifters; only the last DATA_W bits of the frame are kept
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shreg <= '0;
      end else if (sck_rise) begin
         for (int k = 0; k < N_CH; k++) begin
            shreg[k] <= DATA_W'({shreg[k], bus.miso[k]});
         end
      end else begin
         shreg <= shreg;
      end
   end

`ifdef ADC_SAMPLER_AVG_EN
   localparam int ACC_W = DATA_W + AVG_LOG2;
   typedef logic [AVG_LOG2:0] avg_cnt_t;
   localparam avg_cnt_t AVG_LAST = avg_cnt_t'((1 << AVG_LOG2) - 1);

   logic [N_CH-1:0][ACC_W-1:0] acc;
   logic [N_CH-1:0][ACC_W-1:0] acc_sum;
   avg_cnt_t                   avg_cnt;

   assign avg_full = (avg_cnt == AVG_LAST);

   // running sums including the frame being latched, and the truncated mean
   always_comb begin
      acc_sum    = '0;
      latch_data = '0;
      for (int k = 0; k < N_CH; k++) begin
         acc_sum[k] = acc[k] + ACC_W'(shreg[k]);
         latch_data[k*DATA_W +: DATA_W] = DATA_W'(acc_sum[k] >> AVG_LOG2);
      end
   end

   // accumulators restart after every emitted average
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc     <= '0;
         avg_cnt <= '0;
      end else if (state == LATCH) begin
         if (avg_full) begin
            acc     <= '0;
            avg_cnt <= '0;
         end else begin
            acc     <= acc_sum;
            avg_cnt <= avg_cnt + 1'b1;
         end
      end else begin
         acc     <= acc;
         avg_cnt <= avg_cnt;
      end
   end
`else
   assign avg_full   = 1'b1;
   assign latch_data = shreg;
`endif

   // result register; an ack coinciding with a new sample keeps valid high
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.data_out <= '0;
         bus.valid    <= 1'b0;
         bus.overrun  <= 1'b0;
      end else if (latch_out) begin
         bus.data_out <= latch_data;
         bus.valid    <= 1'b1;
         if (bus.valid && !bus.ack) begin
            bus.overrun <= 1'b1;
         end else if (bus.valid && bus.ack) begin
            bus.overrun <= 1'b0;
         end else begin
            bus.overrun <= bus.overrun;
         end
      end else if (bus.valid && bus.ack) begin
         bus.data_out <= bus.data_out;
         bus.valid    <= 1'b0;
         bus.overrun  <= 1'b0;
      end else begin
         bus.data_out <= bus.data_out;
         bus.valid    <= bus.valid;
         bus.overrun  <= bus.overrun;
      end
   end

endmodule
